// File: rtl/mem_bus_initiator_pkg.sv
// Shared bus definitions: packet type, payload and physical address types, memory bound.
// Imported by the bus initiator and its optional read-timeout counter.
package mem_bus_initiator_pkg;

   localparam int PHYS_ADDR_W = 64;
   localparam int BUS_SRC_W   = 4;

   typedef enum logic [0:0] {
      bus_write_data = 1'b0,
      bus_read_data  = 1'b1
   } bus_packet_type_t;

   typedef logic [63:0]            bus_packet_payload_t;
   typedef logic [PHYS_ADDR_W-1:0] phys_memory_address_t;

   // One past the last DRAM byte; an 8-byte access must start below END - 8.
   localparam phys_memory_address_t END_MEMORY_ADDRESS = 64'h0000_0000_0010_0000;

   function automatic logic addr_in_range(input phys_memory_address_t addr);
      return addr < (END_MEMORY_ADDRESS - phys_memory_address_t'(8));
   endfunction

endpackage

// File: rtl/mem_bus_initiator_timeout.sv
// Read-response watchdog: counts cycles while enabled, restarting from 0 whenever disabled.
// Flags expiry in the cycle the count reaches LIMIT-1; no backpressure.
module mem_bus_initiator_timeout #(
   parameter int LIMIT = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic enable,
   output logic expired
);

   localparam logic [31:0] LAST = 32'(LIMIT - 1);

   logic [31:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 32'd1;
      end else begin
         count <= '0;
      end
   end

   assign expired = enable && (count == LAST);

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-outstanding core->bus requester; read timeout built only with MEM_INITIATOR_TIMEOUT_EN.
// Store completes 3 cycles after handshake; core_req_ready low outside IDLE; bus_req held until accept.
module mem_bus_initiator
   import mem_bus_initiator_pkg::*;
#(
   parameter int SOURCE_ID      = 0,
   parameter int ADDR_W         = 64,
   parameter int SRC_W          = BUS_SRC_W,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset_n,

   input  logic              core_req_valid,
   output logic              core_req_ready,
   input  logic              core_req_write,
   input  logic [ADDR_W-1:0] core_req_addr,
   input  logic [63:0]       core_req_wdata,

   output logic              core_rsp_valid,
   output logic [63:0]       core_rsp_rdata,
   output logic              core_rsp_err,

   output logic              bus_req_busy,
   input  logic              bus_req_accept,
   output bus_packet_type_t  bus_req_type,
   output logic [ADDR_W-1:0] bus_req_addr,
   output logic [63:0]       bus_req_payload,
   output logic [SRC_W-1:0]  bus_req_source,

   input  logic              bus_rsp_valid,
   input  logic [63:0]       bus_rsp_payload,
   input  logic [SRC_W-1:0]  bus_rsp_dest
);

   localparam logic [SRC_W-1:0] SRC_ID = SRC_W'(SOURCE_ID);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_READ,
      RESPOND
   } state_t;

   state_t              state;
   logic                done_err;
   bus_packet_payload_t done_data;
   logic                rsp_match;
   logic                timeout_hit;

   assign rsp_match      = bus_rsp_valid && (bus_rsp_dest == SRC_ID);
   assign core_req_ready = (state == IDLE);
   assign bus_req_source = SRC_ID;

`ifdef MEM_INITIATOR_TIMEOUT_EN
   mem_bus_initiator_timeout #(
      .LIMIT   (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (state == WAIT_READ),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         done_err        <= 1'b0;
         done_data       <= '0;
         core_rsp_valid  <= 1'b0;
         core_rsp_rdata  <= '0;
         core_rsp_err    <= 1'b0;
         bus_req_busy    <= 1'b0;
         bus_req_type    <= bus_write_data;
         bus_req_addr    <= '0;
         bus_req_payload <= '0;
      end else begin
         // Completion outputs are only meaningful in the single valid cycle.
         core_rsp_valid <= 1'b0;
         core_rsp_rdata <= '0;
         core_rsp_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (core_req_valid) begin
                  if (addr_in_range(phys_memory_address_t'(core_req_addr))) begin
                     bus_req_type    <= core_req_write ? bus_write_data : bus_read_data;
                     bus_req_addr    <= core_req_addr;
                     bus_req_payload <= core_req_write ? core_req_wdata : 64'd0;
                     bus_req_busy    <= 1'b1;
                     state           <= ISSUE;
                  end else begin
                     done_err  <= 1'b1;
                     done_data <= '0;
                     state     <= RESPOND;
                  end
               end
            end

            ISSUE: begin
               if (bus_req_accept) begin
                  bus_req_busy <= 1'b0;
                  done_err     <= 1'b0;
                  if (bus_req_type == bus_write_data) begin
                     done_data <= '0;
                     state     <= RESPOND;
                  end else if (rsp_match) begin
                     done_data <= bus_rsp_payload;
                     state     <= RESPOND;
                  end else begin
                     state <= WAIT_READ;
                  end
               end
            end

            WAIT_READ: begin
               // A matching response in the expiry cycle takes priority.
               if (rsp_match) begin
                  done_err  <= 1'b0;
                  done_data <= bus_rsp_payload;
                  state     <= RESPOND;
               end else if (timeout_hit) begin
                  done_err  <= 1'b1;
                  done_data <= '0;
                  state     <= RESPOND;
               end
            end

            RESPOND: begin
               core_rsp_valid <= 1'b1;
               core_rsp_err   <= done_err;
               core_rsp_rdata <= done_data;
               state          <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule
